mm_ctrl: RTL and testbench

MM_CTRL -- requirements
Module: mm_ctrl

---
 rtl/mm_pkg.sv | 25 ++
 rtl/mm_ctrl_cnt.sv | 37 +++
 rtl/mm_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mm_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and constants for the systolic-array controller.
package mm_pkg;

  localparam int unsigned PrecMax = 8;
  localparam int unsigned ExpW    = 5;
  localparam int unsigned LenW    = 6;
  localparam int unsigned PrecW   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain
  } mm_state_e;

  // A job is legal when both fields are in range and the weight-bit stream fits a FIFO.
  function automatic logic cfg_ok(logic [LenW-1:0] len, logic [PrecW-1:0] prec,
                                  int unsigned depth);
    logic [LenW+PrecW-1:0] prod;
    prod = {{PrecW{1'b0}}, len} * {{LenW{1'b0}}, prec};
    return (len != '0) && (32'(len) <= depth) && (prec != '0) && (32'(prec) <= PrecMax) &&
           (32'(prod) <= depth);
  endfunction

endpackage

// File: rtl/mm_ctrl_cnt.sv
// Up-counter with synchronous clear and a terminal-count flag that looks at the next value,
// so callers can act in the same cycle the final increment happens.
module mm_ctrl_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [Width-1:0] limit,
  output logic [Width-1:0] cnt,
  output logic             tc
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_d == limit);

endmodule

// File: rtl/mm_ctrl.sv
// Job controller for the systolic array: config check, FIFO load, run, result drain.
// Define MM_CTRL_TIMEOUT_EN to add a RUN-phase watchdog that aborts the job after TIMEOUT cycles.
module mm_ctrl
  import mm_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned ACT_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LenW-1:0]            len,
  input  logic [PrecW-1:0]           precision,
  input  logic [ExpW-1:0]            exp_set,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [N*ACT_WIDTH-1:0]     act_data,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [N-1:0]               w_data,
  output logic                       wr_en_act,
  output logic                       wr_en_w,
  output logic [N*ACT_WIDTH-1:0]     act_din,
  output logic [N-1:0]               w_din,
  output logic                       mm_active,
  output logic [PrecW-1:0]           mm_precision,
  output logic [ExpW-1:0]            mm_exp_set,
  input  logic                       mm_done,
  input  logic [N*N*ACC_WIDTH-1:0]   acc_in,
  input  logic [N*N*ExpW-1:0]        exp_in,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ACC_WIDTH-1:0]       res_acc,
  output logic [ExpW-1:0]            res_exp,
  output logic [$clog2(N*N)-1:0]     res_idx,
  output logic                       busy,
  output logic                       err_cfg,
  output logic                       err_timeout
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IdxW = $clog2(N * N);

  if (N < 2) begin : g_bad_n
    $error("mm_ctrl needs N >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mm_ctrl needs TIMEOUT >= 1");
  end

  mm_state_e        state_q, state_d;
  logic [LenW-1:0]  len_q;
  logic [PrecW-1:0] prec_q;
  logic [ExpW-1:0]  exp_q;
  logic             latch;
  logic             err_cfg_d, err_cfg_q;
  logic             run_timeout;

  logic [CntW-1:0]  act_tgt, w_tgt, act_cnt, w_cnt;
  logic             act_tc, w_tc;
  logic [IdxW-1:0]  idx_cnt;
  logic             unused_idx_tc;
  logic             res_xfer, res_last;

  assign act_tgt = CntW'(len_q);
  assign w_tgt   = CntW'(len_q) * CntW'(prec_q);

  assign act_ready = (state_q == StLoad) && (act_cnt < act_tgt);
  assign w_ready   = (state_q == StLoad) && (w_cnt < w_tgt);
  assign wr_en_act = act_valid && act_ready;
  assign wr_en_w   = w_valid && w_ready;
  assign act_din   = wr_en_act ? act_data : '0;
  assign w_din     = wr_en_w ? w_data : '0;

  assign res_valid = (state_q == StDrain);
  assign res_xfer  = res_valid && res_ready;
  assign res_last  = res_xfer && (idx_cnt == IdxW'(N * N - 1));
  assign res_idx   = idx_cnt;
  assign res_acc   = res_valid ? acc_in[32'(idx_cnt) * ACC_WIDTH +: ACC_WIDTH] : '0;
  assign res_exp   = res_valid ? exp_in[32'(idx_cnt) * ExpW +: ExpW] : '0;

  assign busy         = (state_q != StIdle);
  assign mm_active    = (state_q == StRun);
  assign mm_precision = prec_q;
  assign mm_exp_set   = exp_q;
  assign err_cfg      = err_cfg_q;

  // Stream counters are cleared while idle so a fresh job always starts from zero.
  mm_ctrl_cnt #(.Width(CntW)) u_act_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == StIdle),
    .en    (wr_en_act),
    .limit (act_tgt),
    .cnt   (act_cnt),
    .tc    (act_tc)
  );

  mm_ctrl_cnt #(.Width(CntW)) u_w_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == StIdle),
    .en    (wr_en_w),
    .limit (w_tgt),
    .cnt   (w_cnt),
    .tc    (w_tc)
  );

  mm_ctrl_cnt #(.Width(IdxW)) u_idx_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q != StDrain),
    .en    (res_xfer),
    .limit (IdxW'(N * N - 1)),
    .cnt   (idx_cnt),
    .tc    (unused_idx_tc)
  );

`ifdef MM_CTRL_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] unused_wd_cnt;
  logic           err_to_q;

  // tc fires in the TIMEOUT-th consecutive RUN cycle.
  mm_ctrl_cnt #(.Width(WdW)) u_wd_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q != StRun),
    .en    (state_q == StRun),
    .limit (WdW'(TIMEOUT)),
    .cnt   (unused_wd_cnt),
    .tc    (run_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_to_q <= 1'b0;
    end else begin
      err_to_q <= (state_q == StRun) && !mm_done && run_timeout;
    end
  end

  assign err_timeout = err_to_q;
`else
  assign run_timeout = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    err_cfg_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_ok(len, precision, FIFO_DEPTH)) begin
            latch   = 1'b1;
            state_d = StLoad;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (act_tc && w_tc) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (mm_done) begin
          state_d = StDrain;
        end else if (run_timeout) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (res_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      prec_q    <= '0;
      exp_q     <= '0;
      err_cfg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_cfg_q <= err_cfg_d;
      if (latch) begin
        len_q  <= len;
        prec_q <= precision;
        exp_q  <= exp_set;
      end
    end
  end

endmodule

// File: tb/tb_mm_ctrl.sv
// Randomized self-checking bench for mm_ctrl; expectations come from a job-level model
// (beat counts, legal-config rule, result ordering) rather than the controller's internals.
module tb_mm_ctrl;

  localparam int N   = 2;
  localparam int AW  = 16;
  localparam int CW  = 32;
  localparam int D   = 32;
  localparam int TO  = 16;
  localparam int NP  = N * N;
  localparam int IW  = $clog2(NP);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [5:0]      len;
  logic [3:0]      precision;
  logic [4:0]      exp_set;
  logic            act_valid, act_ready;
  logic [N*AW-1:0] act_data, act_din;
  logic            w_valid, w_ready;
  logic [N-1:0]    w_data, w_din;
  logic            wr_en_act, wr_en_w;
  logic            mm_active;
  logic [3:0]      mm_precision;
  logic [4:0]      mm_exp_set;
  logic            mm_done;
  logic [NP*CW-1:0] acc_in;
  logic [NP*5-1:0] exp_in;
  logic            res_valid, res_ready;
  logic [CW-1:0]   res_acc;
  logic [4:0]      res_exp;
  logic [IW-1:0]   res_idx;
  logic            busy, err_cfg, err_timeout;

  int errors = 0;
  int checks = 0;

  logic [CW-1:0] want_acc [NP];
  logic [4:0]    want_e   [NP];

  mm_ctrl #(.N(N), .ACT_WIDTH(AW), .ACC_WIDTH(CW), .FIFO_DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .precision(precision), .exp_set(exp_set),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .wr_en_act(wr_en_act), .wr_en_w(wr_en_w), .act_din(act_din), .w_din(w_din),
    .mm_active(mm_active), .mm_precision(mm_precision), .mm_exp_set(mm_exp_set),
    .mm_done(mm_done), .acc_in(acc_in), .exp_in(exp_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_acc(res_acc), .res_exp(res_exp),
    .res_idx(res_idx), .busy(busy), .err_cfg(err_cfg), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

  function automatic bit legal(int l, int p);
    return l >= 1 && l <= D && p >= 1 && p <= 8 && l * p <= D;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 6'd4; precision = 4'd2; exp_set = 5'd3;
    act_valid = 1'b1; w_valid = 1'b1; act_data = '1; w_data = '1;
    mm_done = 1'b1; res_ready = 1'b1; acc_in = '1; exp_in = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b0; mm_done = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (act_ready !== 1'b0 || w_ready !== 1'b0 || wr_en_act !== 1'b0 || wr_en_w !== 1'b0)
      begin errors++; $display("FAIL reset_load got=%b%b%b%b want=0000", act_ready, w_ready,
                               wr_en_act, wr_en_w); end
    checks++; if (mm_active !== 1'b0 || res_valid !== 1'b0)
      begin errors++; $display("FAIL reset_run got=%b%b want=00", mm_active, res_valid); end
    checks++; if (mm_precision !== 4'd0 || mm_exp_set !== 5'd0)
      begin errors++; $display("FAIL reset_cfg got=%0d/%0d want=0/0", mm_precision, mm_exp_set); end
    checks++; if (err_cfg !== 1'b0 || err_timeout !== 1'b0)
      begin errors++; $display("FAIL reset_err got=%b%b want=00", err_cfg, err_timeout); end
    checks++; if (res_idx !== '0 || res_acc !== '0 || res_exp !== '0)
      begin errors++; $display("FAIL reset_res got=%0d/%h/%0d want=0", res_idx, res_acc, res_exp); end
    act_valid = 1'b0; w_valid = 1'b0;
  endtask

  task automatic do_start(input int l, input int p, input int e);
    @(negedge clk);
    start = 1'b1; len = 6'(l); precision = 4'(p); exp_set = 5'(e);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_idle busy=%b want=0", busy); end
  endtask

  // Drive both streams until the model says len and len*prec beats have been accepted.
  task automatic load_phase(input int l, input int p, input int e, input bit rand_valid);
    int acts = 0, ws = 0, seen_a = 0, seen_w = 0, cyc = 0;
    int wt = l * p;
    logic want_ar, want_wr;
    while ((acts < l || ws < wt) && cyc < 400) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      len = 6'($urandom); precision = 4'($urandom); exp_set = 5'($urandom);
      mm_done = 1'($urandom);
      act_valid = rand_valid ? 1'($urandom) : 1'b1;
      w_valid = rand_valid ? 1'($urandom) : 1'b1;
      act_data = {$urandom, $urandom};
      w_data = 2'($urandom);
      #1;
      want_ar = (acts < l);
      want_wr = (ws < wt);
      checks++; if (act_ready !== want_ar)
        begin errors++; $display("FAIL load_act_ready got=%b want=%b acts=%0d", act_ready, want_ar, acts); end
      checks++; if (w_ready !== want_wr)
        begin errors++; $display("FAIL load_w_ready got=%b want=%b ws=%0d", w_ready, want_wr, ws); end
      checks++; if (wr_en_act !== (act_valid && want_ar) || wr_en_w !== (w_valid && want_wr))
        begin errors++; $display("FAIL load_wr_en got=%b%b want=%b%b", wr_en_act, wr_en_w,
                                 act_valid && want_ar, w_valid && want_wr); end
      if (act_valid && want_ar) begin
        checks++; if (act_din !== act_data)
          begin errors++; $display("FAIL load_act_din got=%h want=%h", act_din, act_data); end
      end
      checks++; if (mm_active !== 1'b0 || busy !== 1'b1 || err_cfg !== 1'b0)
        begin errors++; $display("FAIL load_state act/busy/err got=%b%b%b want=010", mm_active,
                                 busy, err_cfg); end
      checks++; if (mm_precision !== 4'(p) || mm_exp_set !== 5'(e))
        begin errors++; $display("FAIL load_cfg got=%0d/%0d want=%0d/%0d", mm_precision,
                                 mm_exp_set, p, e); end
      if (wr_en_act === 1'b1) seen_a++;
      if (wr_en_w === 1'b1) seen_w++;
      if (act_valid && want_ar) acts++;
      if (w_valid && want_wr) ws++;
      cyc++;
    end
    checks++; if (seen_a != l || seen_w != wt)
      begin errors++; $display("FAIL load_beats got=%0d/%0d want=%0d/%0d", seen_a, seen_w, l, wt); end
  endtask

  // First iteration is the cycle after the last load beat; mm_done rises in RUN cycle 'delay'.
  task automatic run_phase(input int delay);
    int k = 0, on = 0;
    bit off = 0;
    while (!off && k < delay + 50) begin
      @(negedge clk);
      act_valid = 1'b1; w_valid = 1'b1;
      start = 1'b1; len = 6'd0; precision = 4'd0;
      mm_done = (k == delay);
      #1;
      if (k == 0) begin
        checks++; if (mm_active !== 1'b1)
          begin errors++; $display("FAIL run_entry mm_active=%b want=1", mm_active); end
      end
      checks++; if (act_ready !== 1'b0 || w_ready !== 1'b0 || err_cfg !== 1'b0)
        begin errors++; $display("FAIL run_quiet got=%b%b%b want=000", act_ready, w_ready, err_cfg); end
      if (mm_active === 1'b1) on++; else off = 1;
      k++;
    end
    act_valid = 1'b0; w_valid = 1'b0; start = 1'b0;
    checks++; if (on != delay + 1)
      begin errors++; $display("FAIL run_len active_cycles=%0d want=%0d", on, delay + 1); end
  endtask

  // mode 0: ready toggles 1,0,1..; mode 1: random; mode 2: always ready.
  task automatic drain_phase(input int mode, input int p, input int e);
    int got = 0, cyc = 0;
    for (int q = 0; q < NP; q++) begin
      want_acc[q] = $urandom;
      want_e[q] = 5'($urandom);
      acc_in[q*CW +: CW] = want_acc[q];
      exp_in[q*5 +: 5] = want_e[q];
    end
    while (got < NP && cyc < 200) begin
      mm_done = 1'($urandom);
      start = 1'b0;
      res_ready = (mode == 0) ? (cyc % 2 == 0) : (mode == 1) ? 1'($urandom) : 1'b1;
      #1;
      checks++; if (res_valid !== 1'b1 || busy !== 1'b1)
        begin errors++; $display("FAIL drain_valid got=%b/%b want=1/1 got_cnt=%0d", res_valid, busy, got); end
      checks++; if (res_idx !== IW'(got))
        begin errors++; $display("FAIL drain_idx got=%0d want=%0d", res_idx, got); end
      checks++; if (res_acc !== want_acc[got] || res_exp !== want_e[got])
        begin errors++; $display("FAIL drain_data idx=%0d got=%h/%0d want=%h/%0d", got, res_acc,
                                 res_exp, want_acc[got], want_e[got]); end
      if (res_ready) got++;
      cyc++;
      @(negedge clk);
    end
    res_ready = 1'b0; mm_done = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0)
      begin errors++; $display("FAIL drain_end busy/res_valid got=%b/%b want=0/0", busy, res_valid); end
    checks++; if (mm_precision !== 4'(p) || mm_exp_set !== 5'(e))
      begin errors++; $display("FAIL drain_hold_cfg got=%0d/%0d want=%0d/%0d", mm_precision,
                               mm_exp_set, p, e); end
  endtask

  task automatic run_job(input int l, input int p, input int delay, input int mode);
    int e = int'($urandom_range(0, 31));
    do_start(l, p, e);
    load_phase(l, p, e, 1'b1);
    run_phase(delay);
    drain_phase(mode, p, e);
  endtask

  task automatic test_cfg_errors();
    int bl[6] = '{0, 8, 4, 4, 40, 11};
    int bp[6] = '{1, 8, 0, 9, 1, 3};
    for (int i = 0; i < 10; i++) begin
      int l, p, tries;
      if (i < 6) begin
        l = bl[i]; p = bp[i];
      end else begin
        tries = 0;
        do begin
          l = int'($urandom_range(0, 63)); p = int'($urandom_range(0, 15)); tries++;
        end while (legal(l, p) && tries < 100);
      end
      do_start(l, p, 5);
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++; if (err_cfg !== !legal(l, p) || busy !== legal(l, p))
        begin errors++; $display("FAIL cfg_err len=%0d prec=%0d err/busy got=%b/%b want=%b/%b",
                                 l, p, err_cfg, busy, !legal(l, p), legal(l, p)); end
      @(negedge clk);
      #1;
      checks++; if (err_cfg !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL cfg_pulse err/busy got=%b/%b want=0/0", err_cfg, busy); end
    end
  endtask

  task automatic test_basic();
    int e = 9;
    do_start(4, 2, e);
    load_phase(4, 2, e, 1'b1);
    run_phase(10);
    drain_phase(0, 2, e);
  endtask

  task automatic test_random_jobs();
    int fl[4] = '{32, 1, 4, 16};
    int fp[4] = '{1, 8, 8, 2};
    for (int i = 0; i < 8; i++) begin
      int l, p;
      if (i < 4) begin
        l = fl[i]; p = fp[i];
      end else begin
        do begin
          l = int'($urandom_range(1, 32)); p = int'($urandom_range(1, 8));
        end while (!legal(l, p));
      end
      run_job(l, p, int'($urandom_range(0, 12)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_back_to_back();
    do_start(2, 3, 17);
    load_phase(2, 3, 17, 1'b0);
    run_phase(0);
    drain_phase(2, 3, 17);
    do_start(1, 1, 4);
    load_phase(1, 1, 4, 1'b0);
    run_phase(1);
    drain_phase(2, 1, 4);
  endtask

  task automatic test_reset_mid_load();
    do_start(4, 2, 21);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0; act_valid = 1'b1; w_valid = 1'b0;
      #1;
      checks++; if (wr_en_act !== 1'b1)
        begin errors++; $display("FAIL midrst_beat wr_en_act=%b want=1", wr_en_act); end
    end
    @(negedge clk);
    rst = 1'b1; act_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; act_valid = 1'b1; w_valid = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || act_ready !== 1'b0 || w_ready !== 1'b0 || wr_en_act !== 1'b0 ||
                  wr_en_w !== 1'b0 || mm_active !== 1'b0 || res_valid !== 1'b0)
      begin errors++; $display("FAIL midrst_outputs got=%b%b%b%b%b%b%b want=0000000", busy,
                               act_ready, w_ready, wr_en_act, wr_en_w, mm_active, res_valid); end
    checks++; if (mm_precision !== 4'd0 || mm_exp_set !== 5'd0 || err_cfg !== 1'b0)
      begin errors++; $display("FAIL midrst_cfg got=%0d/%0d/%b want=0/0/0", mm_precision,
                               mm_exp_set, err_cfg); end
    act_valid = 1'b0; w_valid = 1'b0;
    run_job(4, 2, 3, 1);
  endtask

  task automatic test_timeout();
    do_start(2, 1, 6);
    load_phase(2, 1, 6, 1'b0);
`ifdef MM_CTRL_TIMEOUT_EN
    begin
      int on = 0, post = 0, pulses = 0, rv = 0;
      while (post < 4 && on < 100) begin
        @(negedge clk);
        mm_done = 1'b0; act_valid = 1'b0; w_valid = 1'b0; res_ready = 1'b1;
        #1;
        if (mm_active === 1'b1) on++; else post++;
        if (err_timeout === 1'b1) pulses++;
        if (res_valid === 1'b1) rv++;
      end
      res_ready = 1'b0;
      checks++; if (on != TO)
        begin errors++; $display("FAIL timeout_run_len got=%0d want=%0d", on, TO); end
      checks++; if (pulses != 1)
        begin errors++; $display("FAIL timeout_pulse count=%0d want=1", pulses); end
      checks++; if (rv != 0 || busy !== 1'b0)
        begin errors++; $display("FAIL timeout_nodrain res_valid_cycles=%0d busy=%b want=0/0", rv, busy); end
    end
`else
    for (int k = 0; k < 3 * TO; k++) begin
      @(negedge clk);
      mm_done = 1'b0; act_valid = 1'b0; w_valid = 1'b0;
      #1;
      checks++; if (mm_active !== 1'b1 || err_timeout !== 1'b0)
        begin errors++; $display("FAIL run_wait cycle=%0d active/err got=%b/%b want=1/0", k,
                                 mm_active, err_timeout); end
    end
    run_phase(2);
    drain_phase(2, 1, 6);
`endif
  endtask

  initial begin
    test_reset();
    test_cfg_errors();
    test_basic();
    test_random_jobs();
    test_back_to_back();
    test_reset_mid_load();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
